madd_divmod_seq: RTL and testbench
==================================

Name: madd_divmod_seq

Overview:
- Sequential inverse of the pipelined multiply-add datapath.
- Takes a 2*WIDTH-bit sum `s` and a WIDTH-bit factor `b`, and recovers quotient `q = s / b` and remainder `r = s % b`.
- When the original add term satisfied `c < b`, `q` and `r` are exactly the original `a` and `c`.
- Iterative restoring divider, one quotient bit per cycle, with a ready/valid handshake. Sits downstream of the MADD block in the sequential target designs.

Parameters:
- WIDTH, 3, operand width of the factor `b` and remainder `r`. Dividend and quotient are 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request; operands are sampled when `in_valid` and `in_ready` are both high.
- in_ready  output  1  high only in IDLE.
- s  input  2*WIDTH  dividend.
- b  input  WIDTH  divisor.
- out_valid  output  1  one-cycle pulse; result is valid.
- q  output  2*WIDTH  quotient.
- r  output  WIDTH  remainder.
- div_by_zero  output  1  qualifies the current result; set when `b` was 0.

Behaviour:
- Reset (synchronous, active-high, takes priority over everything):
  - state = IDLE, in_ready = 1, out_valid = 0, q = 0, r = 0, div_by_zero = 0.
  - Reset mid-operation abandons the calculation. No out_valid is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On an accept edge, register `s` and `b`, clear the partial remainder (WIDTH+1 bits), load the iteration counter with 2*WIDTH-1, go to CALC.
  - If `b` == 0, latch the zero flag.
- CALC:
  - in_ready = 0.
  - Each cycle: shift the partial remainder left, bringing in the next dividend bit MSB-first.
  - Trial subtract `b`. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - Counter decrements; after exactly 2*WIDTH iterations, go to DONE.
- DONE:
  - Load the output registers q, r, div_by_zero. out_valid = 1 for this single cycle, then return to IDLE.
- Latency: out_valid is high in the cycle beginning 2*WIDTH+1 edges after the accept edge (7 for WIDTH=3). New requests are accepted one cycle after out_valid at the earliest.
- Throughput: one result per 2*WIDTH+2 cycles.
- Outputs q, r, div_by_zero hold their value until the next DONE. They are meaningful only when qualified by out_valid.
- in_valid while not in IDLE is ignored; operands are not queued.
- Divide by zero: the iterations run normally (latency unchanged). The forced result is q = all ones, r = s[WIDTH-1:0], div_by_zero = 1.
- Widths:
  - The partial remainder is WIDTH+1 bits to absorb the shift overflow.
  - The final remainder is always < b and fits WIDTH bits.
  - The quotient may use all 2*WIDTH bits (e.g. b = 1).
- No combinational path from any input to any output.

Optional Feature:
- Macro: MADD_DIVMOD_CHECK_EN.
- Defined:
  - Adds output port `check_err` (1 bit, reset 0), updated in DONE alongside q and r.
  - `check_err` = 1 if `q*b + r != s` for a non-zero `b`, else 0; forced to 0 when div_by_zero.
  - Uses one extra multiplier on the held registered operands.
- Undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Package madd_divmod_pkg:
  - State typedef (IDLE/CALC/DONE).
  - Function returning the counter width, clog2(2*WIDTH).
  - Constant for the divide-by-zero quotient pattern (all ones).
- Sub-module madd_divmod_step (combinational, one restoring iteration):
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
- The top-level instantiates madd_divmod_step once and holds the FSM, counter and registers.

Test Plan (WIDTH=3):
- s=29, b=5, one-cycle in_valid in IDLE -> out_valid exactly 7 cycles later; q=5, r=4, div_by_zero=0; in_ready low for the whole operation.
- s=63, b=1 -> q=63, r=0. Then s=0, b=7 -> q=0, r=0. Back-to-back requests are issued the cycle after out_valid.
- s=42, b=0 -> latency 7, q=63, r=2, div_by_zero=1 (check_err=0 when MADD_DIVMOD_CHECK_EN is defined).
- s=29, b=5 accepted, then in_valid with s=10, b=3 held during CALC -> only one out_valid, carrying q=5, r=4; the second request is accepted after returning to IDLE and gives q=3, r=1.
- rst asserted 3 cycles into CALC -> next cycle in_ready=1, out_valid=0, q=0, r=0. No out_valid pulse from the aborted op; a following s=20, b=6 gives q=3, r=2.
- Exhaustive sweep of all s in 0..63 and b in 1..7 against a reference model; with MADD_DIVMOD_CHECK_EN defined, check_err stays 0 throughout.

Source files
------------

// File: rtl/madd_divmod_pkg.sv
// rtl/madd_divmod_pkg.sv - shared types and constants for the madd_divmod_seq divider
package madd_divmod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Quotient pattern reported for a zero divisor; sliced to the quotient width by users.
    localparam logic [127:0] DBZ_QUOT = '1;

    function automatic int cnt_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/madd_divmod_seq_if.sv
// rtl/madd_divmod_seq_if.sv - request/result bundle of madd_divmod_seq; check_err exists only with MADD_DIVMOD_CHECK_EN
interface madd_divmod_seq_if #(
    parameter int WIDTH = 3
);
    import madd_divmod_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   s;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   q;
    logic [WIDTH-1:0]     r;
    logic                 div_by_zero;
`ifdef MADD_DIVMOD_CHECK_EN
    logic                 check_err;

    modport master (
        output in_valid, s, b,
        input  in_ready, out_valid, q, r, div_by_zero, check_err
    );

    modport slave (
        input  in_valid, s, b,
        output in_ready, out_valid, q, r, div_by_zero, check_err
    );
`else
    modport master (
        output in_valid, s, b,
        input  in_ready, out_valid, q, r, div_by_zero
    );

    modport slave (
        input  in_valid, s, b,
        output in_ready, out_valid, q, r, div_by_zero
    );
`endif

endinterface

// File: rtl/madd_divmod_step.sv
// rtl/madd_divmod_step.sv - one combinational restoring-division iteration
module madd_divmod_step
    import madd_divmod_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             quot_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // One spare bit above the shifted remainder makes diff's MSB a borrow flag.
    assign shifted  = {rem_in, dividend_bit};
    assign diff     = shifted - {2'b00, divisor};
    assign quot_bit = ~diff[WIDTH+1];
    assign rem_out  = quot_bit ? diff[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/madd_divmod_seq.sv
// rtl/madd_divmod_seq.sv - sequential restoring divider s/b, s%b; optional check_err with MADD_DIVMOD_CHECK_EN
module madd_divmod_seq
    import madd_divmod_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    madd_divmod_seq_if.slave  bus
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DW - 1);

    state_t           state_q, state_d;
    logic [DW-1:0]    dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] s_lo_q;
    logic [WIDTH:0]   rem_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic [DW-1:0]    q_q;
    logic [WIDTH-1:0] r_q;
    logic             dbz_q;
    logic             out_valid_q;
    logic [WIDTH:0]   rem_next;
    logic             quot_bit;

    madd_divmod_step #(.WIDTH(WIDTH)) u_step (
        .rem_in       (rem_q),
        .dividend_bit (dvd_q[DW-1]),
        .divisor      (dvs_q),
        .rem_out      (rem_next),
        .quot_bit     (quot_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = CALC;
            end
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            s_lo_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    dvd_q  <= bus.s;
                    dvs_q  <= bus.b;
                    s_lo_q <= bus.s[WIDTH-1:0];
                    rem_q  <= '0;
                    cnt_q  <= CNT_LOAD;
                    zero_q <= (bus.b == '0);
                end
                CALC: begin
                    dvd_q <= {dvd_q[DW-2:0], quot_bit};
                    rem_q <= rem_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: begin
                    out_valid_q <= 1'b1;
                    q_q         <= zero_q ? DBZ_QUOT[DW-1:0] : dvd_q;
                    r_q         <= zero_q ? s_lo_q : rem_q[WIDTH-1:0];
                    dbz_q       <= zero_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.q           = q_q;
    assign bus.r           = r_q;
    assign bus.div_by_zero = dbz_q;

`ifdef MADD_DIVMOD_CHECK_EN
    logic [DW-1:0]        s_full_q;
    logic                 chk_q;
    logic [3*WIDTH-1:0]   recon;

    assign recon = ({{WIDTH{1'b0}}, dvd_q} * {{DW{1'b0}}, dvs_q})
                 + {{DW{1'b0}}, rem_q[WIDTH-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            s_full_q <= '0;
            chk_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.in_valid) s_full_q <= bus.s;
            if (state_q == DONE) chk_q <= !zero_q && (recon != {{WIDTH{1'b0}}, s_full_q});
        end
    end

    assign bus.check_err = chk_q;
`endif

endmodule

// File: tb/tb_madd_divmod_seq.sv
// tb/tb_madd_divmod_seq.sv - self-checking bench for madd_divmod_seq (WIDTH=3), MADD_DIVMOD_CHECK_EN aware
module tb_madd_divmod_seq;

    localparam int W       = 3;
    localparam int LATENCY = 2 * W + 1;

    typedef struct {
        int s;
        int b;
        int acc;
    } req_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    req_t exp_q[$];

    madd_divmod_seq_if #(.WIDTH(W)) bus ();

    madd_divmod_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor convention applied.
    always @(negedge clk) begin
        req_t e;
        int   eq, er, edz;
        if (!rst && bus.out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out_valid: got out_valid=1, required 0 (nothing pending)");
            end else begin
                e = exp_q.pop_front();
                if (e.b == 0) begin
                    eq  = (1 << (2 * W)) - 1;
                    er  = e.s % (1 << W);
                    edz = 1;
                end else begin
                    eq  = e.s / e.b;
                    er  = e.s % e.b;
                    edz = 0;
                end
                chk("latency", 64'(cyc - e.acc), 64'(LATENCY));
                chk("q", 64'(bus.q), 64'(eq));
                chk("r", 64'(bus.r), 64'(er));
                chk("div_by_zero", 64'(bus.div_by_zero), 64'(edz));
`ifdef MADD_DIVMOD_CHECK_EN
                chk("check_err", 64'(bus.check_err), 64'd0);
`endif
            end
        end
    end

    task automatic send(input int sv, input int bv);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.s        = sv[2*W-1:0];
        bus.b        = bv[W-1:0];
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_q.push_back('{sv, bv, cyc});
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clk);
            n++;
        end
        chk("result_seen", 64'(bus.out_valid), 64'd1);
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.s        = '0;
        bus.b        = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_q", 64'(bus.q), 64'd0);
        chk("rst_r", 64'(bus.r), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        send(29, 5);
        wait_result();
        chk("t1_q", 64'(bus.q), 64'd5);
        chk("t1_r", 64'(bus.r), 64'd4);
        chk("t1_dbz", 64'(bus.div_by_zero), 64'd0);

        @(negedge clk);
        send(63, 1);
        wait_result();
        chk("t2_q", 64'(bus.q), 64'd63);
        chk("t2_r", 64'(bus.r), 64'd0);
        @(negedge clk);
        chk("b2b_ready", 64'(bus.in_ready), 64'd1);
        send(0, 7);
        wait_result();
        chk("t2b_q", 64'(bus.q), 64'd0);
        chk("t2b_r", 64'(bus.r), 64'd0);

        @(negedge clk);
        send(42, 0);
        wait_result();
        chk("t3_q", 64'(bus.q), 64'd63);
        chk("t3_r", 64'(bus.r), 64'd2);
        chk("t3_dbz", 64'(bus.div_by_zero), 64'd1);

        @(negedge clk);
        send(29, 5);
        bus.in_valid = 1'b1;
        bus.s        = 6'd10;
        bus.b        = 3'd3;
        wait_result();
        chk("t4a_q", 64'(bus.q), 64'd5);
        chk("t4a_r", 64'(bus.r), 64'd4);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_q.push_back('{10, 3, cyc});
        wait_result();
        chk("t4b_q", 64'(bus.q), 64'd3);
        chk("t4b_r", 64'(bus.r), 64'd1);

        @(negedge clk);
        send(50, 7);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
        chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_q", 64'(bus.q), 64'd0);
        chk("t5_r", 64'(bus.r), 64'd0);
        repeat (12) @(negedge clk);
        send(20, 6);
        wait_result();
        chk("t5b_q", 64'(bus.q), 64'd3);
        chk("t5b_r", 64'(bus.r), 64'd2);

        for (int sv = 0; sv < 64; sv++) begin
            for (int bv = 1; bv < 8; bv++) begin
                @(negedge clk);
                send(sv, bv);
                wait_result();
            end
        end

        repeat (4) @(negedge clk);
        chk("pending_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
